// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory-port arbiter.
//   state_e       : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_e       : which requester owns the in-flight transaction
//   ADDR_W_DEFAULT: default physical address width (Sv32 PA)
//   TIMEOUT_RDATA : read data returned to the owner on a watchdog timeout
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int          ADDR_W_DEFAULT = 34;
  localparam logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Combinational two-requester picker.
//   req_i, req_d : request lines
//   last_grant   : side that received the previous grant
//   fixed_prio_d : 1 = D wins simultaneous requests, 0 = alternate
//   gnt_valid    : at least one request present
//   gnt_owner    : selected side (meaningful only with gnt_valid)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e last_grant,
  input  logic   fixed_prio_d,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  // Pick the winner; on a tie hand the grant to the side that waited last time.
  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_owner = OWN_I;
    if (req_i && req_d) begin
      if (fixed_prio_d) begin
        gnt_owner = OWN_D;
      end else if (last_grant == OWN_I) begin
        gnt_owner = OWN_D;
      end else begin
        gnt_owner = OWN_I;
      end
    end else if (req_d) begin
      gnt_owner = OWN_D;
    end else begin
      gnt_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one physical memory port between the I-side and D-side MMU/caches.
// One request is latched at a time, driven on the memory bus until mem_ready
// (or a watchdog timeout), and answered with a one-cycle ready to its owner.
//   clk, resetn                      : clock, synchronous active-low reset
//   i_*/d_* valid,wstrb,addr,wdata   : requester inputs (sampled in IDLE only)
//   i_*/d_* ready,rdata,err          : per-side completion, data, timeout flag
//   mem_valid,wstrb,addr,wdata       : latched request toward memory
//   mem_ready, mem_rdata             : memory completion and read data
//   busy, timeout_err                : status; timeout pulse with errored ready
//   i_grant_count, d_grant_count     : wrapping per-side grant counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit FIXED_PRIO_D   = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [3:0]        i_wstrb,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_valid,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              timeout_err,
  output logic [31:0]       i_grant_count,
  output logic [31:0]       d_grant_count
);

  // A zero TIMEOUT_CYCLES disables the watchdog entirely.
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              err_q, err_d;
  logic [31:0]       wd_q, wd_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [31:0]       i_cnt_q, i_cnt_d;
  logic [31:0]       d_cnt_q, d_cnt_d;

  logic   gnt_valid;
  owner_e gnt_owner;

  arb_rr2 u_pick (
    .req_i        (i_valid),
    .req_d        (d_valid),
    .last_grant   (last_q),
    .fixed_prio_d (FIXED_PRIO_D),
    .gnt_valid    (gnt_valid),
    .gnt_owner    (gnt_owner)
  );

  // Next-state logic: grant in IDLE, wait for memory or watchdog in BUSY.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    err_d     = err_q;
    wd_d      = wd_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = BUSY;
          owner_d = gnt_owner;
          last_d  = gnt_owner;
          err_d   = 1'b0;
          wd_d    = 32'd0;
          if (gnt_owner == OWN_D) begin
            wstrb_d = d_wstrb;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            d_cnt_d = d_cnt_q + 32'd1;
          end else begin
            wstrb_d = i_wstrb;
            addr_d  = i_addr;
            wdata_d = i_wdata;
            i_cnt_d = i_cnt_q + 32'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          // wd_q counts completed BUSY cycles, so this fires on cycle TIMEOUT_CYCLES.
          state_d = RESP;
          err_d   = 1'b1;
          if (owner_q == OWN_D) begin
            d_rdata_d = TIMEOUT_RDATA;
          end else begin
            i_rdata_d = TIMEOUT_RDATA;
          end
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves the round-robin favouring I.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_D;
      err_q     <= 1'b0;
      wd_q      <= 32'd0;
      wstrb_q   <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_cnt_q   <= 32'd0;
      d_cnt_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  // Outputs are pure decodes of registered state, so they carry no input paths.
  assign mem_valid     = (state_q == BUSY);
  assign busy          = (state_q != IDLE);
  assign i_ready       = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ready       = (state_q == RESP) && (owner_q == OWN_D);
  assign i_err         = i_ready && err_q;
  assign d_err         = d_ready && err_q;
  assign timeout_err   = (state_q == RESP) && err_q;
  assign mem_wstrb     = wstrb_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign i_grant_count = i_cnt_q;
  assign d_grant_count = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized transactions, checked against a
// transaction-level model of the arbitration, data-return and timeout rules.
module tb_mem_port_arbiter;

  localparam int AW = 34;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          i_valid, d_valid, mem_ready, echo_mode;
  logic [3:0]    i_wstrb, d_wstrb;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   i_wdata, d_wdata, mem_rdata, mem_rdata_drv;
  logic          i_ready, d_ready, i_err, d_err, mem_valid, busy, timeout_err;
  logic [31:0]   i_rdata, d_rdata, mem_wdata, i_grant_count, d_grant_count;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  // outputs of the fixed-priority instance
  logic          p_i_ready, p_d_ready, p_i_err, p_d_err, p_mem_valid, p_busy, p_timeout_err;
  logic [31:0]   p_i_rdata, p_d_rdata, p_mem_wdata, p_i_grant_count, p_d_grant_count;
  logic [3:0]    p_mem_wstrb;
  logic [AW-1:0] p_mem_addr;

  // Simple memory: either echoes the aligned address or returns a chosen word.
  assign mem_rdata = echo_mode ? {mem_addr[31:6], 6'b0} : mem_rdata_drv;

  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .FIXED_PRIO_D(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .FIXED_PRIO_D(1'b1)) dut_p (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(p_i_ready), .i_rdata(p_i_rdata), .i_err(p_i_err),
    .d_valid(d_valid), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(p_d_ready), .d_rdata(p_d_rdata), .d_err(p_d_err),
    .mem_valid(p_mem_valid), .mem_ready(mem_ready), .mem_wstrb(p_mem_wstrb),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata),
    .busy(p_busy), .timeout_err(p_timeout_err),
    .i_grant_count(p_i_grant_count), .d_grant_count(p_d_grant_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] exp_i_rdata, exp_d_rdata, exp_i_cnt, exp_d_cnt;
  bit          prefer_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; d_valid = 1'b0;
    i_wstrb = 4'h0; d_wstrb = 4'h0;
    i_addr = '0; d_addr = '0;
    i_wdata = 32'h0; d_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata_drv = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    exp_i_cnt = 32'h0; exp_d_cnt = 32'h0;
    prefer_d = 1'b0;
  endtask

  // One complete transaction from an IDLE cycle: grant, BUSY, RESP, back to IDLE.
  // wait_n = extra BUSY cycles before mem_ready; tmo = never answer.
  task automatic run_txn(input bit iv, input bit dv,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [31:0] iw, input logic [31:0] dw,
                         input logic [3:0] is, input logic [3:0] ds,
                         input int wait_n, input bit tmo, input bit hold,
                         input logic [31:0] rd);
    bit            od;
    logic [AW-1:0] oa;
    logic [31:0]   ow, exp_rd;
    logic [3:0]    os;
    int            nb;
    i_valid = iv; d_valid = dv;
    i_addr = ia; d_addr = da; i_wdata = iw; d_wdata = dw; i_wstrb = is; d_wstrb = ds;
    mem_ready = 1'($urandom);        // ignored while IDLE
    mem_rdata_drv = rd;
    od = (iv && dv) ? prefer_d : dv;
    prefer_d = !od;
    if (od) exp_d_cnt = exp_d_cnt + 32'd1;
    else    exp_i_cnt = exp_i_cnt + 32'd1;
    oa = od ? da : ia;
    ow = od ? dw : iw;
    os = od ? ds : is;
    exp_rd = tmo ? 32'h0 : (echo_mode ? {oa[31:6], 6'b0} : rd);
    step();
    chk("mem_addr", 64'(mem_addr), 64'(oa));
    chk("mem_wdata", 64'(mem_wdata), 64'(ow));
    chk("mem_wstrb", 64'(mem_wstrb), 64'(os));
    chk("i_grant_count", 64'(i_grant_count), 64'(exp_i_cnt));
    chk("d_grant_count", 64'(d_grant_count), 64'(exp_d_cnt));
    if (!hold) begin
      // requester inputs must be ignored while the transaction is in flight
      i_valid = 1'($urandom); d_valid = 1'($urandom);
      i_addr = AW'({$urandom, $urandom}); d_addr = AW'({$urandom, $urandom});
      i_wdata = $urandom; d_wdata = $urandom;
    end
    nb = tmo ? TO : wait_n + 1;
    for (int b = 1; b <= nb; b++) begin
      mem_ready = 1'(!tmo && (b == nb));
      chk("busy_in_busy", 64'(busy), 64'd1);
      chk("mem_valid_in_busy", 64'(mem_valid), 64'd1);
      chk("no_ready_in_busy", 64'({i_ready, d_ready}), 64'd0);
      step();
    end
    if (od) exp_d_rdata = exp_rd;
    else    exp_i_rdata = exp_rd;
    chk("i_ready_resp", 64'(i_ready), 64'(!od));
    chk("d_ready_resp", 64'(d_ready), 64'(od));
    chk("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
    chk("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
    chk("i_err", 64'(i_err), 64'(!od && tmo));
    chk("d_err", 64'(d_err), 64'(od && tmo));
    chk("timeout_err", 64'(timeout_err), 64'(tmo));
    chk("mem_valid_resp", 64'(mem_valid), 64'd0);
    mem_ready = 1'($urandom);        // ignored in RESP
    if (!hold) begin
      i_valid = 1'b0; d_valid = 1'b0;
    end
    step();
    chk("busy_after_resp", 64'(busy), 64'd0);
    chk("ready_single_pulse", 64'({i_ready, d_ready, timeout_err}), 64'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    echo_mode = 1'b0;
    do_reset();

    // reset values
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_ready", 64'({i_ready, d_ready, i_err, d_err, timeout_err}), 64'd0);
    chk("rst_mem_fields", 64'({mem_wstrb, mem_wdata}) | 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
    chk("rst_counts", 64'({i_grant_count, d_grant_count}), 64'd0);

    // zero-wait I read with echo memory
    echo_mode = 1'b1;
    run_txn(1'b1, 1'b0, 34'h500, 34'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0);
    chk("zero_wait_i_rdata", 64'(i_rdata), 64'h500);

    // fixed-priority instance: D wins a simultaneous request from reset
    do_reset();
    i_valid = 1'b1; d_valid = 1'b1; i_addr = 34'h100; d_addr = 34'h200;
    step();
    chk("prio_d_first_addr", 64'(p_mem_addr), 64'h200);
    chk("prio_d_count", 64'({p_i_grant_count, p_d_grant_count}), 64'h1);
    chk("rr_i_first_addr", 64'(mem_addr), 64'h100);

    // round-robin: simultaneous reads from reset, I first then D
    do_reset();
    run_txn(1'b1, 1'b1, 34'h100, 34'h200, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0);
    run_txn(1'b1, 1'b1, 34'h100, 34'h200, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0);
    chk("simul_counts", 64'({i_grant_count, d_grant_count}), 64'h0000_0001_0000_0001);
    chk("simul_rdata", 64'({i_rdata, d_rdata}), 64'h0000_0100_0000_0200);

    // D write; the I-side rdata register must keep 0x100
    run_txn(1'b0, 1'b1, 34'h0, 34'h600, 32'h0, 32'h6666_6666, 4'h0, 4'hF, 1, 1'b0, 1'b0, 32'h0);
    chk("write_i_rdata_kept", 64'(i_rdata), 64'h100);
    echo_mode = 1'b0;

    // D read timeout, then a normal D read
    run_txn(1'b0, 1'b1, 34'h0, 34'h700, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("timeout_d_rdata", 64'(d_rdata), 64'h0);
    run_txn(1'b0, 1'b1, 34'h0, 34'h704, 32'h0, 32'h0, 4'h0, 4'h0, 2, 1'b0, 1'b0, 32'h1234_5678);

    // both held valid for six transactions: strict alternation
    for (int k = 0; k < 6; k++) begin
      run_txn(1'b1, 1'b1, 34'h3_0000_0040, 34'h2_0000_0080, 32'hA5A5_0000, 32'h5A5A_0000,
              4'h3, 4'hC, k % 3, 1'b0, (k != 5), 32'h0000_1000 + 32'(k));
    end

    // reset pulse during BUSY discards the transaction
    i_valid = 1'b1; i_addr = 34'h900; mem_ready = 1'b0;
    step();
    i_valid = 1'b0;
    step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rst_busy_idle", 64'(busy), 64'd0);
    chk("rst_busy_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_busy_counts", 64'({i_grant_count, d_grant_count}), 64'd0);
    chk("rst_busy_no_ready", 64'({i_ready, d_ready}), 64'd0);
    step();
    chk("rst_busy_still_quiet", 64'({i_ready, d_ready, busy}), 64'd0);
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    exp_i_cnt = 32'h0; exp_d_cnt = 32'h0;
    prefer_d = 1'b0;

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      bit iv, dv;
      iv = 1'($urandom);
      dv = 1'($urandom);
      if (!iv && !dv) iv = 1'b1;
      run_txn(iv, dv, AW'({$urandom, $urandom}), AW'({$urandom, $urandom}),
              $urandom, $urandom, 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0), 1'b0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
